uart_frame_transmitter: RTL and testbench

Parametrised UART transmitter. It is the successor to the fixed 8N1 transmitter and adds configurable data width, parity mode and stop-bit count, plus a busy flag. It pulls words from a registered-output FIFO through an empty/re handshake and serialises each word LSB-first onto dout. It sits between the TX FIFO and the pad, alongside the existing receiver.

---
 rtl/uart_frame_transmitter.sv | 170 +++++++++++++++++
 tb/tb_uart_frame_transmitter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_transmitter.sv
// Parametrised UART transmitter: pulls one word per frame from a FIFO (empty/re)
// and serialises it LSB-first with optional parity and one or two stop bits.
module uart_frame_transmitter #(
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115200,
  parameter logic [31:0] WORD_WIDTH      = 32'd8,
  parameter logic [1:0]  PARITY_MODE     = 2'd0,
  parameter logic [31:0] STOP_BITS       = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic                  empty,
  output logic                  re,
  output logic                  dout,
  output logic                  busy
);

  localparam logic [31:0] BIT_CYCLES = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int TIMER_W = (BIT_CYCLES > 32'd1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W   = $clog2(WORD_WIDTH + 32'd1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BIT_CYCLES - 32'd1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(WORD_WIDTH - 32'd1);
  localparam logic               STOP_LAST  = (STOP_BITS == 32'd2);

  if (WORD_WIDTH < 32'd5 || WORD_WIDTH > 32'd9) begin : g_bad_width
    $error("uart_frame_transmitter: WORD_WIDTH must be 5..9");
  end
  if (PARITY_MODE == 2'd3) begin : g_bad_parity
    $error("uart_frame_transmitter: PARITY_MODE 3 is illegal");
  end
  if (STOP_BITS != 32'd1 && STOP_BITS != 32'd2) begin : g_bad_stop
    $error("uart_frame_transmitter: STOP_BITS must be 1 or 2");
  end
  if (BIT_CYCLES == 32'd0) begin : g_bad_baud
    $error("uart_frame_transmitter: BAUD_RATE exceeds CLOCK_FREQUENCY");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_ENABLE, S_LOAD_DATA, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
  } state_t;

  function automatic logic parity_f(input logic [WORD_WIDTH-1:0] word, input logic [1:0] mode);
    case (mode)
      2'd1:    return ^word;
      2'd2:    return ~^word;
      default: return 1'b0;
    endcase
  endfunction

  state_t                state_r, state_s;
  logic [TIMER_W-1:0]    timer_r, timer_s;
  logic [BIT_W-1:0]      bit_r, bit_s;
  logic                  stop_r, stop_s;
  logic [WORD_WIDTH-1:0] data_r, data_s, shifted_s;
  logic                  parity_r, parity_s;
  logic                  dout_r, dout_s, re_r, re_s, busy_r, busy_s;
  logic                  wrap_s;

  assign wrap_s = (timer_r == TIMER_LAST);

  // Next-state, counter and capture logic; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_s   = state_r;
    timer_s   = {TIMER_W{1'b0}};
    bit_s     = bit_r;
    stop_s    = stop_r;
    data_s    = data_r;
    parity_s  = parity_r;
    dout_s    = 1'b1;
    re_s      = 1'b0;
    busy_s    = 1'b1;
    shifted_s = {WORD_WIDTH{1'b0}};
    case (state_r)
      S_IDLE: begin
        bit_s  = {BIT_W{1'b0}};
        stop_s = 1'b0;
        if (!empty) begin
          state_s = S_SEND_ENABLE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SEND_ENABLE: state_s = S_LOAD_DATA;
      S_LOAD_DATA: begin
        data_s   = din;
        parity_s = parity_f(din, PARITY_MODE);
        state_s  = S_START;
      end
      S_START: begin
        if (wrap_s) begin
          state_s = S_DATA;
        end else begin
          timer_s = timer_r + TIMER_W'(1);
        end
      end
      S_DATA: begin
        if (wrap_s) begin
          if (bit_r == BIT_LAST) begin
            state_s = (PARITY_MODE != 2'd0) ? S_PARITY : S_STOP;
          end else begin
            bit_s = bit_r + BIT_W'(1);
          end
        end else begin
          timer_s = timer_r + TIMER_W'(1);
        end
      end
      S_PARITY: begin
        if (wrap_s) begin
          state_s = S_STOP;
        end else begin
          timer_s = timer_r + TIMER_W'(1);
        end
      end
      S_STOP: begin
        if (wrap_s) begin
          if (stop_r == STOP_LAST) begin
            state_s = S_WAIT;
          end else begin
            stop_s = 1'b1;
          end
        end else begin
          timer_s = timer_r + TIMER_W'(1);
        end
      end
      S_WAIT:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase

    shifted_s = data_s >> bit_s;
    case (state_s)
      S_IDLE:        busy_s = 1'b0;
      S_SEND_ENABLE: re_s   = 1'b1;
      S_START:       dout_s = 1'b0;
      S_DATA:        dout_s = shifted_s[0];
      S_PARITY:      dout_s = parity_s;
      default:       dout_s = 1'b1;
    endcase
  end

  // State, counters, captured word and registered line outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      timer_r  <= {TIMER_W{1'b0}};
      bit_r    <= {BIT_W{1'b0}};
      stop_r   <= 1'b0;
      data_r   <= {WORD_WIDTH{1'b0}};
      parity_r <= 1'b0;
      dout_r   <= 1'b1;
      re_r     <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      bit_r    <= bit_s;
      stop_r   <= stop_s;
      data_r   <= data_s;
      parity_r <= parity_s;
      dout_r   <= dout_s;
      re_r     <= re_s;
      busy_r   <= busy_s;
    end
  end

  assign dout = dout_r;
  assign re   = re_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_uart_frame_transmitter.sv
// Directed bench: 8N1, 8E1 and 7O2 instances at default timing (868 cycles/bit),
// checking frame slots, re handshake, back-to-back frames and async reset.
module tb_uart_frame_transmitter;

  localparam int BC = 868;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din0, din1;
  logic [6:0] din2;
  logic [2:0] empty_v;
  logic [2:0] re_v, dout_v, busy_v;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         re_cnt0 = 0, re_cnt1 = 0, re_cnt2 = 0;

  uart_frame_transmitter u_dut0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .empty(empty_v[0]),
    .re(re_v[0]), .dout(dout_v[0]), .busy(busy_v[0])
  );
  uart_frame_transmitter #(.PARITY_MODE(2'd1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din1), .empty(empty_v[1]),
    .re(re_v[1]), .dout(dout_v[1]), .busy(busy_v[1])
  );
  uart_frame_transmitter #(.WORD_WIDTH(32'd7), .PARITY_MODE(2'd2), .STOP_BITS(32'd2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .empty(empty_v[2]),
    .re(re_v[2]), .dout(dout_v[2]), .busy(busy_v[2])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (re_v[0] === 1'b1) re_cnt0 <= re_cnt0 + 1;
    if (re_v[1] === 1'b1) re_cnt1 <= re_cnt1 + 1;
    if (re_v[2] === 1'b1) re_cnt2 <= re_cnt2 + 1;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Waits (bounded) for the re pulse of instance i, then walks the whole frame slot by slot.
  // Returns with the WAIT cycle just sampled.
  task automatic frame(input int i, input logic [8:0] word, input int wbits, input int has_par,
                       input logic par_bit, input int stops, input bit pulse, output int re_cyc);
    bit   found = 1'b0;
    logic exp;
    int   nslots;
    re_cyc = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      step();
      if (re_v[i] === 1'b1) found = 1'b1;
    end
    check_eq("re_seen", {31'd0, found}, 32'd1);
    if (!found) return;
    re_cyc = cyc;
    check_eq("send_busy", {31'd0, busy_v[i]}, 32'd1);
    check_eq("send_dout", {31'd0, dout_v[i]}, 32'd1);
    if (pulse) empty_v[i] = 1'b1;
    step();
    check_eq("load_re", {31'd0, re_v[i]}, 32'd0);
    check_eq("load_dout", {31'd0, dout_v[i]}, 32'd1);
    nslots = 1 + wbits + has_par + stops;
    for (int s = 0; s < nslots; s++) begin
      if (s == 0) exp = 1'b0;
      else if (s <= wbits) exp = word[s-1];
      else if (has_par != 0 && s == wbits + 1) exp = par_bit;
      else exp = 1'b1;
      for (int c = 0; c < BC; c++) begin
        step();
        if (c == 0 || c == BC - 1) begin
          check_eq("slot_dout", {31'd0, dout_v[i]}, {31'd0, exp});
        end
        if (c == 0) check_eq("slot_busy", {31'd0, busy_v[i]}, 32'd1);
      end
    end
    step();
    check_eq("wait_dout", {31'd0, dout_v[i]}, 32'd1);
    check_eq("wait_busy", {31'd0, busy_v[i]}, 32'd1);
    check_eq("wait_re", {31'd0, re_v[i]}, 32'd0);
  endtask

  initial begin
    int a, b, bad, r0;
    bit found;
    rst_n   = 1'b0;
    empty_v = 3'b111;
    din0    = 8'h00;
    din1    = 8'h00;
    din2    = 7'h00;
    #23;
    check_eq("rst_dout", {29'd0, dout_v}, 32'h7);
    check_eq("rst_re", {29'd0, re_v}, 32'h0);
    check_eq("rst_busy", {29'd0, busy_v}, 32'h0);
    rst_n = 1'b1;

    // empty held high: line stays idle, no reads
    bad = 0;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (re_v !== 3'b000 || dout_v !== 3'b111 || busy_v !== 3'b000) bad++;
    end
    check_eq("idle_bad_cycles", bad, 32'd0);
    check_eq("idle_reads", re_cnt0 + re_cnt1 + re_cnt2, 32'd0);

    // 8N1, A5 -> 0,1,0,1,0,0,1,0,1,1
    din0 = 8'hA5;
    empty_v[0] = 1'b0;
    frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, a);
    step();
    check_eq("t1_idle_busy", {31'd0, busy_v[0]}, 32'd0);
    check_eq("t1_idle_dout", {31'd0, dout_v[0]}, 32'd1);
    check_eq("t1_len", cyc - a, 3 + BC * 10);
    check_eq("t1_reads", re_cnt0, 32'd1);

    // 8E1, A5 has four ones -> parity 0
    din1 = 8'hA5;
    empty_v[1] = 1'b0;
    frame(1, 9'h0A5, 8, 1, 1'b0, 1, 1'b1, a);
    step();
    check_eq("t2_len", cyc - a, 32'd9551);
    check_eq("t2_idle_busy", {31'd0, busy_v[1]}, 32'd0);

    // 7O2, 35 -> 1,0,1,0,1,1,0, parity 1, two stop slots
    din2 = 7'h35;
    empty_v[2] = 1'b0;
    frame(2, 9'h035, 7, 1, 1'b1, 2, 1'b1, a);
    step();
    check_eq("t3_len", cyc - a, 3 + BC * 11);
    check_eq("t3_reads", re_cnt2, 32'd1);

    // back-to-back: re-to-re is one frame (3+10*BC) plus the single IDLE cycle
    r0 = re_cnt0;
    din0 = 8'h00;
    empty_v[0] = 1'b0;
    frame(0, 9'h000, 8, 0, 1'b0, 1, 1'b0, a);
    din0 = 8'hFF;
    frame(0, 9'h0FF, 8, 0, 1'b0, 1, 1'b0, b);
    empty_v[0] = 1'b1;
    check_eq("t4_spacing", b - a, 4 + BC * 10);
    step();
    step();
    check_eq("t4_idle_re", {31'd0, re_v[0]}, 32'd0);
    check_eq("t4_idle_busy", {31'd0, busy_v[0]}, 32'd0);
    check_eq("t4_reads", re_cnt0 - r0, 32'd2);

    // async reset in the middle of data bit 3 (A5 bit 3 = 0)
    din0 = 8'hA5;
    empty_v[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      step();
      if (re_v[0] === 1'b1) found = 1'b1;
    end
    check_eq("t5_re_seen", {31'd0, found}, 32'd1);
    empty_v[0] = 1'b1;
    for (int k = 0; k < 4 * BC + 2 + 100; k++) step();
    check_eq("t5_bit3_dout", {31'd0, dout_v[0]}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_dout", {31'd0, dout_v[0]}, 32'd1);
    check_eq("t5_rst_busy", {31'd0, busy_v[0]}, 32'd0);
    check_eq("t5_rst_re", {31'd0, re_v[0]}, 32'd0);
    #3;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10000; k++) begin
      step();
      if (dout_v[0] !== 1'b1 || re_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
    end
    check_eq("t5_post_bad_cycles", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
